// File: rtl/glyph_draw_ctrl.sv
// glyph_draw_ctrl
//  Draws one 8x16 digit glyph by scanning the shared glyph ROM address
//  (row-major, addr 0..127), picking the requested digit's q bit and turning
//  it into a coloured pixel write on a valid/ready stream.
//
//  ROM reads take one cycle, so at most one read is in flight at a time.
//  Captured pixels land in a 2-entry FIFO. A read is only issued when the
//  FIFO is guaranteed to have room for it.
//
//  Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   req_valid/req_ready  draw request handshake (ready only in IDLE)
//   req_digit            0-9 selects ROM_n, 10-15 draws a blank glyph
//   req_x, req_y         glyph top-left corner
//   req_fg, req_bg       colours for set and clear bits
//   rom_addr             shared ROM address (row*8+col)
//   rom_q                bit n = ROM_n data, valid one cycle after rom_addr
//   pix_valid/pix_ready  pixel stream handshake
//   pix_x, pix_y         pixel coordinates; they wrap modulo 2^X_W and 2^Y_W
//   pix_color            pixel colour
//   busy                 high outside IDLE
//   done                 one-cycle pulse when a glyph completes
//
//  Build option: TRANSPARENT_BG_EN
//   When defined, clear bits are skipped, so only foreground pixels are emitted.
//
//  state | meaning
//  IDLE  | waiting for a draw request
//  SCAN  | issuing ROM reads for addr 0..127
//  DRAIN | waiting for the in-flight read and the FIFO to empty
module glyph_draw_ctrl #(
   parameter int X_W     = 9,
   parameter int Y_W     = 9,
   parameter int COLOR_W = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [3:0]         req_digit,
   input  logic [X_W-1:0]     req_x,
   input  logic [Y_W-1:0]     req_y,
   input  logic [COLOR_W-1:0] req_fg,
   input  logic [COLOR_W-1:0] req_bg,
   output logic [6:0]         rom_addr,
   input  logic [9:0]         rom_q,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [X_W-1:0]     pix_x,
   output logic [Y_W-1:0]     pix_y,
   output logic [COLOR_W-1:0] pix_color,
   output logic               busy,
   output logic               done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SCAN  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]         state;
   logic [6:0]         addr;
   logic               inflight;
   logic [6:0]         inf_addr;
   logic [3:0]         lat_digit;
   logic [X_W-1:0]     lat_x;
   logic [Y_W-1:0]     lat_y;
   logic [COLOR_W-1:0] lat_fg;
   logic [COLOR_W-1:0] lat_bg;

   logic [X_W-1:0]     fifo_x [2];
   logic [Y_W-1:0]     fifo_y [2];
   logic [COLOR_W-1:0] fifo_c [2];
   logic               wr_ptr;
   logic               rd_ptr;
   logic [1:0]         count;

   logic               pop;
   logic               push;
   logic               issue;
   logic               rom_bit;
   logic [2:0]         occ;

   assign pix_valid = (count != 2'd0);
   assign pix_x     = fifo_x[rd_ptr];
   assign pix_y     = fifo_y[rd_ptr];
   assign pix_color = fifo_c[rd_ptr];
   assign pop       = pix_valid & pix_ready;

   // Room check: occupancy after this cycle's pop plus the datum that is
   // already in flight. A new read is issued only if that leaves a free slot.
   assign occ   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
   assign issue = (state == S_SCAN) && (occ < 3'd2);

   assign rom_addr  = addr;
   assign req_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DRAIN) && !inflight && (count == 2'd0);

   // Codes 10-15 match no ROM, so they read as a blank glyph.
   always_comb begin
      rom_bit = 1'b0;
      for (int n = 0; n < 10; n++) begin
         if (lat_digit == 4'(n)) rom_bit = rom_q[n];
      end
   end

`ifdef TRANSPARENT_BG_EN
   assign push = inflight & rom_bit;
`else
   assign push = inflight;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_IDLE;
         addr      <= 7'd0;
         inflight  <= 1'b0;
         inf_addr  <= 7'd0;
         lat_digit <= 4'd0;
         lat_x     <= '0;
         lat_y     <= '0;
         lat_fg    <= '0;
         lat_bg    <= '0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         count     <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            fifo_x[i] <= '0;
            fifo_y[i] <= '0;
            fifo_c[i] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  lat_digit <= req_digit;
                  lat_x     <= req_x;
                  lat_y     <= req_y;
                  lat_fg    <= req_fg;
                  lat_bg    <= req_bg;
                  addr      <= 7'd0;
                  state     <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (issue) begin
                  addr <= addr + 7'd1;
                  if (addr == 7'd127) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (!inflight && (count == 2'd0)) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         inflight <= issue;
         if (issue) inf_addr <= addr;

         if (push) begin
            fifo_x[wr_ptr] <= lat_x + X_W'(inf_addr[2:0]);
            fifo_y[wr_ptr] <= lat_y + Y_W'(inf_addr[6:3]);
            fifo_c[wr_ptr] <= rom_bit ? lat_fg : lat_bg;
            wr_ptr         <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_glyph_draw_ctrl.sv
module tb_glyph_draw_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_digit;
   logic [8:0]  req_x;
   logic [8:0]  req_y;
   logic [15:0] req_fg;
   logic [15:0] req_bg;
   logic [6:0]  rom_addr;
   logic [9:0]  rom_q = '0;
   logic        pix_valid;
   logic        pix_ready;
   logic [8:0]  pix_x;
   logic [8:0]  pix_y;
   logic [15:0] pix_color;
   logic        busy;
   logic        done;

   glyph_draw_ctrl #(.X_W(9), .Y_W(9), .COLOR_W(16)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_digit(req_digit),
      .req_x(req_x), .req_y(req_y), .req_fg(req_fg), .req_bg(req_bg),
      .rom_addr(rom_addr), .rom_q(rom_q),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
      .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   // Glyph contents; digit 9 row 3 is fixed so cols 2..4 are set.
   function automatic logic gbit(int d, int a);
      logic [7:0] r;
      int row, col;
      row = a / 8;
      col = a % 8;
      r = 8'((d * 37 + row * 53 + 11) ^ (row * d));
      if (d == 9 && row == 3) r = 8'b0001_1100;
      return r[col];
   endfunction

   always @(posedge clock)
      for (int n = 0; n < 10; n++) rom_q[n] <= gbit(n, int'(rom_addr));

   typedef struct {
      logic [8:0]  x;
      logic [8:0]  y;
      logic [15:0] c;
   } pix_t;

   pix_t exp_q[$];
   int   done_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   accepts = 0;
   int   acc_cyc = 0;
   int   gidx = 0;
   int   test_id = 0;
   bit   exact = 1'b1;
   bit   rand_mode = 1'b0;
   bit   prev_stall = 1'b0;
   pix_t prev_p;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Sink ready: held high, or random when rand_mode is set.
   initial begin
      pix_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         pix_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor / scoreboard
   always @(negedge clock) begin
      if (!reset) begin
         chk("ready_vs_busy", {31'd0, req_ready}, {31'd0, ~busy});
         if (req_valid && req_ready) begin
            pix_t p;
            logic b;
            accepts++;
            acc_cyc = cyc;
            gidx = 0;
            for (int a = 0; a < 128; a++) begin
               b = (req_digit <= 4'd9) ? gbit(int'(req_digit), a) : 1'b0;
               p.x = req_x + 9'(a % 8);
               p.y = req_y + 9'(a / 8);
               p.c = b ? req_fg : req_bg;
`ifdef TRANSPARENT_BG_EN
               if (b) exp_q.push_back(p);
`else
               exp_q.push_back(p);
`endif
            end
`ifdef TRANSPARENT_BG_EN
            done_q.push_back(-1);
`else
            done_q.push_back(exact ? cyc + 131 : -1);
`endif
         end
         if (prev_stall) begin
            chk("stall_valid", {31'd0, pix_valid}, 32'd1);
            chk("stall_data", {5'd0, pix_x, pix_y, 9'd0}, {5'd0, prev_p.x, prev_p.y, 9'd0});
            chk("stall_color", {16'd0, pix_color}, {16'd0, prev_p.c});
         end
         if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
               chk("extra_pixel", {23'd0, pix_x}, 32'hFFFF_FFFF);
            end else begin
               pix_t e;
               e = exp_q.pop_front();
               chk("pix_x", {23'd0, pix_x}, {23'd0, e.x});
               chk("pix_y", {23'd0, pix_y}, {23'd0, e.y});
               chk("pix_color", {16'd0, pix_color}, {16'd0, e.c});
            end
            if (gidx == 0 && exact) chk("first_pix_latency", cyc, acc_cyc + 3);
            if (test_id == 1 && gidx == 26) begin
               chk("t1_addr26_x", {23'd0, pix_x}, 32'd12);
               chk("t1_addr26_y", {23'd0, pix_y}, 32'd23);
               chk("t1_addr26_c", {16'd0, pix_color}, 32'hFFFF);
            end
            if (test_id == 4 && gidx == 0) begin
               chk("t4_first_x", {23'd0, pix_x}, 32'd508);
               chk("t4_first_y", {23'd0, pix_y}, 32'd510);
            end
            if (test_id == 4 && gidx == 127) begin
               chk("t4_last_x", {23'd0, pix_x}, 32'd3);
               chk("t4_last_y", {23'd0, pix_y}, 32'd13);
            end
            gidx++;
         end
         if (done) begin
            if (done_q.size() == 0) begin
               chk("spurious_done", 32'd1, 32'd0);
            end else begin
               int e;
               e = done_q.pop_front();
               if (e >= 0) chk("done_cycle", cyc, e);
               chk("pixels_left_at_done", exp_q.size(), 32'd0);
            end
         end
         prev_stall = pix_valid && !pix_ready;
         prev_p.x = pix_x;
         prev_p.y = pix_y;
         prev_p.c = pix_color;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic send(input logic [3:0] d, input logic [8:0] x, input logic [8:0] y,
                       input logic [15:0] fg, input logic [15:0] bg);
      int base;
      int n;
      base = accepts;
      req_digit = d; req_x = x; req_y = y; req_fg = fg; req_bg = bg;
      req_valid = 1'b1;
      n = 0;
      while (accepts == base && n < 500) begin
         @(posedge clock);
         #1;
         n++;
      end
      if (accepts == base) chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && done_q.size() == 0 && !busy) && n < 3000) begin
         @(posedge clock);
         #1;
         n++;
      end
      chk("glyph_complete", {31'd0, (exp_q.size() == 0 && done_q.size() == 0 && !busy)}, 32'd1);
      repeat (3) @(posedge clock);
      #1;
   endtask

   initial begin
      int n;
      int base;
      reset = 1'b1;
      req_valid = 1'b0;
      req_digit = '0; req_x = '0; req_y = '0; req_fg = '0; req_bg = '0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rom_addr", {25'd0, rom_addr}, 32'd0);
      chk("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      @(posedge clock);
      #1;

      // 1: digit 9, full rate
      test_id = 1;
      send(4'd9, 9'd10, 9'd20, 16'hFFFF, 16'h0000);
      wait_idle();

      // 2: same request under random backpressure
      test_id = 2; exact = 1'b0; rand_mode = 1'b1;
      send(4'd9, 9'd10, 9'd20, 16'hFFFF, 16'h0000);
      wait_idle();
      rand_mode = 1'b0; exact = 1'b1;
      @(posedge clock);
      #1;

      // 3: blank glyph
      test_id = 3;
      send(4'd12, 9'd40, 9'd50, 16'h1234, 16'hABCD);
      wait_idle();

      // 4: coordinate wrap
      test_id = 4;
      send(4'd3, 9'd508, 9'd510, 16'hF800, 16'h07E0);
      wait_idle();

      // 5: reset at pixel 40
      test_id = 5;
      send(4'd5, 9'd100, 9'd100, 16'h00FF, 16'hFF00);
      n = 0;
      while (gidx < 40 && n < 500) begin
         @(posedge clock);
         #1;
         n++;
      end
      chk("t5_reach_pixel40", {31'd0, (gidx >= 40)}, 32'd1);
      reset = 1'b1;
      exp_q.delete();
      done_q.delete();
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("t5_pix_valid_after_rst", {31'd0, pix_valid}, 32'd0);
      chk("t5_busy_after_rst", {31'd0, busy}, 32'd0);
      repeat (20) @(posedge clock);
      #1;
      send(4'd7, 9'd30, 9'd60, 16'hAAAA, 16'h5555);
      wait_idle();

      // 6: req_valid held high, digits 0 then 9 back to back
      test_id = 6;
      base = accepts;
      req_digit = 4'd0; req_x = 9'd200; req_y = 9'd150; req_fg = 16'h0F0F; req_bg = 16'hF0F0;
      req_valid = 1'b1;
      n = 0;
      while (accepts == base && n < 500) begin
         @(posedge clock);
         #1;
         n++;
      end
      req_digit = 4'd9; req_x = 9'd210; req_y = 9'd160;
      n = 0;
      while (accepts < base + 2 && n < 500) begin
         @(posedge clock);
         #1;
         n++;
      end
      req_valid = 1'b0;
      wait_idle();
      chk("t6_accept_count", accepts - base, 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
